// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch/next-PC controller and the next-PC calculator.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        UPDATE = 2'd2,
        ERROR  = 2'd3
    } state_e;

    localparam logic [5:0]  OP_J    = 6'h02;
    localparam logic [5:0]  OP_JAL  = 6'h03;
    localparam logic [5:0]  OP_BEQ  = 6'h04;
    localparam logic [5:0]  OP_BNE  = 6'h05;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch or jump target.
module next_pc_calc
    import pc_ctrl_pkg::*;
(
    input  logic [31:0] pc_q,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic        is_jump,
    output logic        is_branch
);

    logic [5:0]  opcode;
    logic [31:0] seq;
    logic [31:0] br_off;

    assign opcode = instr[31:26];
    assign seq    = pc_q + PC_STEP;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc   = seq;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        if (opcode == OP_J || opcode == OP_JAL) begin
            next_pc = {seq[31:28], instr[25:0], 2'b00};
            is_jump = 1'b1;
        end else if ((opcode == OP_BEQ && alu_zero) || (opcode == OP_BNE && !alu_zero)) begin
            next_pc   = seq + br_off;
            is_branch = 1'b1;
        end
    end

endmodule

// File: rtl/pc_next_ctrl.sv
// Multi-cycle fetch / execute-wait / PC-update controller driving the PC load interface.
module pc_next_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_in,
    output logic        pc_enable,
    output logic        pc_jump,
    output logic        pc_branch,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        alu_zero,
    output logic        fetch_err
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        instr_q, instr_d;
    logic               vld_q, vld_d;
    logic [31:0]        pc_in_q, pc_in_d;
    logic               jump_q, jump_d;
    logic               branch_q, branch_d;
    logic               err_q, err_d;

    logic [31:0]        calc_pc;
    logic               calc_jump;
    logic               calc_branch;

    next_pc_calc u_calc (
        .pc_q      (pc_q),
        .instr     (instr_q),
        .alu_zero  (alu_zero),
        .next_pc   (calc_pc),
        .is_jump   (calc_jump),
        .is_branch (calc_branch)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= FETCH;
            wait_q   <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            instr_q  <= '0;
            vld_q    <= 1'b0;
            pc_in_q  <= '0;
            jump_q   <= 1'b0;
            branch_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            pc_in_q  <= pc_in_d;
            jump_q   <= jump_d;
            branch_q <= branch_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        req_d    = req_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        vld_d    = vld_q;
        pc_in_d  = pc_in_q;
        jump_d   = jump_q;
        branch_d = branch_q;
        err_d    = err_q;
        case (state_q)
            FETCH: begin
                req_d  = 1'b1;
                addr_d = pc_q;
                // An ack only counts once the request is visible; an ack on the limit cycle still wins.
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    vld_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = EXEC;
                end else if (wait_q == WAIT_LIM) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            EXEC: begin
                if (exec_done) begin
                    pc_in_d  = calc_pc;
                    jump_d   = calc_jump;
                    branch_d = calc_branch;
                    vld_d    = 1'b0;
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                wait_d   = '0;
                jump_d   = 1'b0;
                branch_d = 1'b0;
                state_d  = FETCH;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Gated by Rst so a reset landing on the update cycle suppresses the load.
    always_comb begin
        pc_enable = 1'b0;
        if (state_q == UPDATE && !Rst)
            pc_enable = 1'b1;
    end

    assign pc_in       = pc_in_q;
    assign pc_jump     = jump_q;
    assign pc_branch   = branch_q;
    assign imem_addr   = addr_q;
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign fetch_err   = err_q;

endmodule
